// File: rtl/bar_sequencer.sv
// Spectrum bar sequencer: captures 64 FFT bar heights, then commits them one bar per cycle
// (direct copy or peak-hold with decay) and hands off to the pattern generator.
module bar_sequencer #(
  parameter int ACK_TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bin_valid,
  input  logic [5:0]   bin_idx,
  input  logic [4:0]   bin_mag,
  input  logic         frame_tick,
  input  logic         decay_en,
  input  logic         pg_busy,
  output logic         pg_start,
  output logic [319:0] bars,
  output logic         busy,
  output logic [7:0]   overrun_cnt,
  output logic         timeout_flag
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, COMMIT, START, WAIT_ACK, RUN} state_t;

  state_t        state_q, state_d;
  logic [6:0]    idx_q, idx_d;
  logic [TW-1:0] to_q, to_d;
  logic          complete_q, complete_d;
  logic          pg_start_q, pg_start_d;
  logic [7:0]    ovr_q, ovr_d;
  logic          tflag_q, tflag_d;
  logic [4:0]    capture_q [64];
  logic [4:0]    capture_d [64];
  logic [4:0]    display_q [64];
  logic [4:0]    display_d [64];

  function automatic logic [4:0] clamp16(input logic [4:0] mag);
    return (mag > 5'd16) ? 5'd16 : mag;
  endfunction

  function automatic logic [4:0] commit_val(input logic decay, input logic [4:0] cap,
                                            input logic [4:0] disp);
    if (!decay || cap >= disp) return cap;
    else if (disp != 5'd0)     return disp - 5'd1;
    else                       return 5'd0;
  endfunction

  always_comb begin
    capture_d = capture_q;
    display_d = display_q;
    if (bin_valid) capture_d[bin_idx] = clamp16(bin_mag);
    // Commit reads capture_q, so a same-cycle capture write to this bar is not seen yet.
    if (state_q == COMMIT && !idx_q[6])
      display_d[idx_q[5:0]] = commit_val(decay_en, capture_q[idx_q[5:0]], display_q[idx_q[5:0]]);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    to_d       = to_q;
    complete_d = complete_q;
    ovr_d      = ovr_q;
    tflag_d    = tflag_q;
    case (state_q)
      IDLE: begin
        if (frame_tick && complete_q) begin
          state_d = COMMIT;
          idx_d   = '0;
        end
      end
      // Index 64 is a settle cycle after the last bar so the start pulse lands one edge later.
      COMMIT: begin
        if (idx_q[6]) state_d = START;
        else          idx_d   = idx_q + 7'd1;
      end
      START: begin
        state_d = WAIT_ACK;
        to_d    = '0;
      end
      WAIT_ACK: begin
        if (pg_busy) begin
          state_d = RUN;
        end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = IDLE;
          tflag_d = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      RUN: begin
        if (!pg_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (frame_tick && state_q != IDLE && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    if (state_q == IDLE && state_d == COMMIT) complete_d = 1'b0;
    if (bin_valid && bin_idx == 6'd63) complete_d = 1'b1;
    pg_start_d = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      to_q       <= '0;
      complete_q <= 1'b0;
      pg_start_q <= 1'b0;
      ovr_q      <= '0;
      tflag_q    <= 1'b0;
      for (int k = 0; k < 64; k++) begin
        capture_q[k] <= '0;
        display_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      to_q       <= to_d;
      complete_q <= complete_d;
      pg_start_q <= pg_start_d;
      ovr_q      <= ovr_d;
      tflag_q    <= tflag_d;
      capture_q  <= capture_d;
      display_q  <= display_d;
    end
  end

  for (genvar g = 0; g < 64; g++) begin : g_bars
    assign bars[5*g +: 5] = display_q[g];
  end

  assign pg_start     = pg_start_q;
  assign busy         = (state_q != IDLE);
  assign overrun_cnt  = ovr_q;
  assign timeout_flag = tflag_q;

endmodule
